// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-side arbiter and its schedulers.
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   function automatic int unsigned credit_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int unsigned id_w(input int unsigned nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side valid/ready bundle; slice i of req_data belongs to requester i.
interface fifo_wr_arbiter_if #(
   parameter int unsigned NREQ       = 4,
   parameter int unsigned fifo_width = 8
);
   logic [NREQ-1:0]            req_valid;
   logic [NREQ*fifo_width-1:0] req_data;
   logic [NREQ-1:0]            req_ready;

   modport master (output req_valid, output req_data, input  req_ready);
   modport slave  (input  req_valid, input  req_data, output req_ready);
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit of req at or above ptr, wrapping at N-1.
module rr_pick #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          vld,
   output logic [IW-1:0] idx
);

   int unsigned cand;

   always_comb begin
      vld  = 1'b0;
      idx  = '0;
      cand = 0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = (32'(ptr) + k) % N;
         if (!vld && (|(req & (N'(1) << cand)))) begin
            vld = 1'b1;
            idx = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded write-port arbiter in front of a synchronous FIFO,
// with a local credit counter so no write is ever issued to a full FIFO.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NREQ       = 4,
   parameter int unsigned fifo_depth = 8,
   parameter int unsigned fifo_width = 8,
   parameter int unsigned BURST_LEN  = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   fifo_wr_arbiter_if.slave                  req_if,
   output logic                              fifo_write,
   output logic [fifo_width-1:0]             fifo_data_in,
   input  logic                              fifo_read,
   input  logic                              fifo_empty,
   input  logic                              fifo_full,
   output logic [credit_w(fifo_depth)-1:0]   credit,
   output logic [id_w(NREQ)-1:0]             grant_id,
   output logic                              cnt_err
);

   localparam int unsigned CREDIT_W = credit_w(fifo_depth);
   localparam int unsigned ID_W     = id_w(NREQ);
   localparam int unsigned BEAT_W   = $clog2(BURST_LEN + 1);
   localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(fifo_depth);
   localparam logic [BEAT_W-1:0]   BEAT_LAST  = BEAT_W'(BURST_LEN);

   arb_state_e            state_q, state_d;
   logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]       owner_q, owner_d;
   logic [BEAT_W-1:0]     beats_q, beats_d;
   logic [CREDIT_W-1:0]   credit_q, credit_d;
   logic                  fifo_write_q, fifo_write_d;
   logic [fifo_width-1:0] fifo_data_q, fifo_data_d;
   logic [ID_W-1:0]       grant_id_q, grant_id_d;
   logic                  cnt_err_q, cnt_err_d;

   logic                  pick_vld;
   logic [ID_W-1:0]       pick_idx;
   logic [NREQ-1:0]       grant_c;
   logic                  xfer_c;
   logic [ID_W-1:0]       xfer_idx_c;
   logic                  pop_c;
   logic [fifo_width-1:0] lane_data [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_lane
      assign lane_data[g] = req_if.req_data[g*fifo_width +: fifo_width];
   end

   rr_pick #(
      .N  (NREQ),
      .IW (ID_W)
   ) u_rr_pick (
      .req (req_if.req_valid),
      .ptr (rr_ptr_q),
      .vld (pick_vld),
      .idx (pick_idx)
   );

   function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] p);
      return (p == ID_W'(NREQ - 1)) ? '0 : p + ID_W'(1);
   endfunction

   assign pop_c = fifo_read && !fifo_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         owner_q      <= '0;
         beats_q      <= '0;
         credit_q     <= CREDIT_MAX;
         fifo_write_q <= 1'b0;
         fifo_data_q  <= '0;
         grant_id_q   <= '0;
         cnt_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         owner_q      <= owner_d;
         beats_q      <= beats_d;
         credit_q     <= credit_d;
         fifo_write_q <= fifo_write_d;
         fifo_data_q  <= fifo_data_d;
         grant_id_q   <= grant_id_d;
         cnt_err_q    <= cnt_err_d;
      end
   end

   // Grant depends only on state, registered credit and req_valid; fifo_read never reaches it.
   always_comb begin
      grant_c    = '0;
      xfer_idx_c = owner_q;
      if (!rst && credit_q != '0) begin
         unique case (state_q)
            IDLE: begin
               if (pick_vld) begin
                  grant_c    = NREQ'(1) << pick_idx;
                  xfer_idx_c = pick_idx;
               end
            end
            BURST: begin
               if (req_if.req_valid[owner_q] && beats_q < BEAT_LAST) begin
                  grant_c = NREQ'(1) << owner_q;
               end
            end
         endcase
      end
      xfer_c = |(grant_c & req_if.req_valid);
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      owner_d      = owner_q;
      beats_d      = beats_q;
      credit_d     = credit_q;
      fifo_write_d = xfer_c;
      fifo_data_d  = fifo_data_q;
      grant_id_d   = grant_id_q;
      cnt_err_d    = cnt_err_q;

      if (xfer_c) begin
         fifo_data_d = lane_data[xfer_idx_c];
         grant_id_d  = xfer_idx_c;
      end

      // Burst ends on its last beat or on the first cycle the owner cannot transfer.
      unique case (state_q)
         IDLE: begin
            if (xfer_c) begin
               owner_d = xfer_idx_c;
               beats_d = BEAT_W'(1);
               if (BURST_LEN > 1) state_d  = BURST;
               else               rr_ptr_d = ptr_inc(xfer_idx_c);
            end
         end
         BURST: begin
            if (xfer_c) beats_d = beats_q + BEAT_W'(1);
            if (!xfer_c || (beats_q + BEAT_W'(1)) >= BEAT_LAST) begin
               state_d  = IDLE;
               rr_ptr_d = ptr_inc(owner_q);
            end
         end
      endcase

      unique case ({xfer_c, pop_c})
         2'b10: begin
            if (credit_q == '0) cnt_err_d = 1'b1;
            else                credit_d  = credit_q - CREDIT_W'(1);
         end
         2'b01: begin
            if (credit_q == CREDIT_MAX) cnt_err_d = 1'b1;
            else                        credit_d  = credit_q + CREDIT_W'(1);
         end
         default: ;
      endcase

      // A full FIFO with free credit and nothing in flight means the two views diverged.
      if (fifo_full && credit_q != '0 && !fifo_write_q) cnt_err_d = 1'b1;
   end

   assign req_if.req_ready = grant_c;
   assign fifo_write       = fifo_write_q;
   assign fifo_data_in     = fifo_data_q;
   assign credit           = credit_q;
   assign grant_id         = grant_id_q;
   assign cnt_err          = cnt_err_q;

endmodule
